// File: rtl/hex_printer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_printer_pkg
// Description : Shared types and constants for the hex printer: FSM state
//               encoding, output byte selector, ASCII codes and terminator
//               (SEP) encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_printer_pkg;

  // Printer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    TERM1 = 2'd2,
    TERM2 = 2'd3
  } state_t;

  // Source of the next registered output byte.
  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_DIGIT = 3'd1,
    SEL_CR    = 3'd2,
    SEL_LF    = 3'd3,
    SEL_SPACE = 3'd4
  } out_sel_t;

  // ASCII codes.
  localparam logic [7:0] c_ascii_cr    = 8'h0D;
  localparam logic [7:0] c_ascii_lf    = 8'h0A;
  localparam logic [7:0] c_ascii_space = 8'h20;
  localparam logic [7:0] c_ascii_zero  = 8'h30;
  localparam logic [7:0] c_ascii_a     = 8'h41;

  // Terminator selection encodings for the SEP parameter.
  localparam int c_sep_crlf  = 0;
  localparam int c_sep_space = 1;
  localparam int c_sep_none  = 2;

endpackage : hex_printer_pkg
`default_nettype wire

// File: rtl/hex_printer_digit.sv
`default_nettype none
// ============================================================================
// Module      : hex_digit_ascii
// Description : Purely combinational conversion of one hex nibble to its
//               uppercase ASCII character (0-9 -> 0x30-0x39, A-F -> 0x41-0x46).
// Ports       : i_nibble [3:0] - hex value to convert
//               o_ascii  [7:0] - ASCII character code
// Revision    : 1.0 - initial release
// ============================================================================
module hex_digit_ascii
  import hex_printer_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  always_comb begin
    o_ascii = c_ascii_zero;
    if (i_nibble < 4'd10) begin
      o_ascii = c_ascii_zero + {4'b0000, i_nibble};
    end else begin
      o_ascii = c_ascii_a + ({4'b0000, i_nibble} - 8'd10);
    end
  end

endmodule : hex_digit_ascii
`default_nettype wire

// File: rtl/hex_printer.sv
`default_nettype none
// ============================================================================
// Module      : hex_printer
// Description : Accepts a 32-bit word over a valid/ready input port and emits
//               its low DIGITS nibbles as uppercase ASCII hex characters (most
//               significant first) over a valid/ready byte port, followed by an
//               optional terminator (CR LF, space or nothing, chosen by SEP).
// Parameters  : DIGITS - hex digits per word (1..8)
//               SEP    - 0 = CR LF, 1 = space, 2 = no terminator
// Ports       : clock     - sole clock, rising edge
//               reset     - synchronous, active-high
//               in_valid  - in_data holds a word to print
//               in_ready  - block accepts a word this cycle (IDLE only)
//               in_data   - word to print, bits [4*DIGITS-1:0] used
//               out_valid - out_data holds an ASCII byte
//               out_ready - downstream takes out_data this cycle
//               out_data  - ASCII byte
// Revision    : 1.0 - initial release
// ============================================================================
module hex_printer
  import hex_printer_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int SEP    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data
);

  localparam int c_sw = 4 * DIGITS;

  state_t            state_q, state_d;
  logic [c_sw-1:0]   shift_q, shift_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  out_sel_t          out_sel;
  logic [7:0]        digit_ascii;

  // Bits of in_data above the printed field are intentionally ignored.
  if (c_sw < 32) begin : g_unused_hi
    logic unused_in_hi;
    assign unused_in_hi = ^in_data[31:c_sw];
  end

  // The converter looks at the top nibble of the shift register's next value,
  // so the character for a digit is ready to be registered in the same cycle
  // that the digit moves to the top (capture or shift). This gives the
  // one-cycle latency from input transfer to first output byte.
  hex_digit_ascii u_digit (
    .i_nibble (shift_d[c_sw-1 -: 4]),
    .o_ascii  (digit_ascii)
  );

  // Next-state, datapath control and output-valid decode.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sel     = SEL_HOLD;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d     = in_data[c_sw-1:0];
          cnt_d       = 3'(DIGITS - 1);
          state_d     = DIGIT;
          out_valid_d = 1'b1;
          out_sel     = SEL_DIGIT;
        end
      end

      DIGIT: begin
        if (out_ready) begin
          if (cnt_q != 3'd0) begin
            cnt_d   = cnt_q - 3'd1;
            shift_d = shift_q << 4;
            out_sel = SEL_DIGIT;
          end else if (SEP == c_sep_crlf) begin
            state_d = TERM1;
            out_sel = SEL_CR;
          end else if (SEP == c_sep_space) begin
            state_d = TERM1;
            out_sel = SEL_SPACE;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end

      TERM1: begin
        if (out_ready) begin
          if (SEP == c_sep_crlf) begin
            state_d = TERM2;
            out_sel = SEL_LF;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end

      TERM2: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Output byte mux; kept apart from the FSM block so the converter path
  // (shift_d -> digit_ascii) does not loop back into the block that made it.
  always_comb begin
    out_data_d = out_data_q;
    unique case (out_sel)
      SEL_DIGIT: out_data_d = digit_ascii;
      SEL_CR:    out_data_d = c_ascii_cr;
      SEL_LF:    out_data_d = c_ascii_lf;
      SEL_SPACE: out_data_d = c_ascii_space;
      default:   out_data_d = out_data_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // in_ready is a pure decode of the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule : hex_printer
`default_nettype wire
